// File: rtl/preset_sequencer.sv
// Footswitch preset sequencer: keeps three MIDI program slots and sends Program Change messages.
// Optional MIDI running status (status byte sent only once after reset) via `define PRESET_RUNNING_STATUS_EN.
module preset_sequencer #(
  parameter logic [3:0] MIDI_CHANNEL = 4'd0,
  parameter logic [6:0] PRESET0_INIT = 7'd0,
  parameter logic [6:0] PRESET1_INIT = 7'd1,
  parameter logic [6:0] PRESET2_INIT = 7'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn_index,
  input  logic       save_mode,
  input  logic       rx_prog_valid,
  input  logic [6:0] rx_prog,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       saved,
  output logic [1:0] active_slot,
  output logic [1:0] state_dbg
);

  // TX handshake: a byte moves when tx_valid && tx_ready in the same cycle; while
  // tx_valid is high and tx_ready low, tx_data and tx_valid stay unchanged.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STATUS = 2'd1,
    DATA   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] slot_q [3];
  logic [6:0] cap_prog_q;
  logic       cap_valid_q;
  logic       pend_valid_q;
  logic [1:0] pend_slot_q;
  logic [6:0] msg_q;
  logic       rs_skip;

  logic       save_evt, recall_evt, save_ok, start;
  logic [6:0] save_prog;
  logic [1:0] start_slot;
  logic [6:0] start_prog;

  assign save_evt   = (btn_index != 2'd0) && save_mode;
  assign recall_evt = (btn_index != 2'd0) && !save_mode;
  // A program arriving in the same cycle as a save goes straight into the slot.
  assign save_prog  = rx_prog_valid ? rx_prog : cap_prog_q;
  assign save_ok    = save_evt && (rx_prog_valid || cap_valid_q);
  assign start      = (state_q == IDLE) && (recall_evt || pend_valid_q);
  assign start_slot = recall_evt ? btn_index : pend_slot_q;

  always_comb begin
    start_prog = slot_q[2];
    case (start_slot)
      2'd1:    start_prog = slot_q[0];
      2'd2:    start_prog = slot_q[1];
      default: start_prog = slot_q[2];
    endcase
  end

`ifdef PRESET_RUNNING_STATUS_EN
  logic rs_sent_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rs_sent_q <= 1'b0;
    else if (state_q == STATUS && tx_ready) rs_sent_q <= 1'b1;
  end

  assign rs_skip = rs_sent_q;
`else
  assign rs_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      slot_q[0]    <= PRESET0_INIT;
      slot_q[1]    <= PRESET1_INIT;
      slot_q[2]    <= PRESET2_INIT;
      cap_prog_q   <= 7'd0;
      cap_valid_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_slot_q  <= 2'd0;
      msg_q        <= 7'd0;
      saved        <= 1'b0;
      active_slot  <= 2'd0;
    end else begin
      state_q <= state_d;
      saved   <= save_ok;
      if (rx_prog_valid) begin
        cap_prog_q  <= rx_prog;
        cap_valid_q <= 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        if (save_ok && btn_index == 2'(i + 1)) slot_q[i] <= save_prog;
      end
      // Recalls arriving mid-message park here; the newest one wins.
      if (recall_evt && state_q != IDLE) begin
        pend_valid_q <= 1'b1;
        pend_slot_q  <= btn_index;
      end else if (start) begin
        pend_valid_q <= 1'b0;
      end
      if (start) begin
        msg_q       <= start_prog;
        active_slot <= start_slot;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    tx_valid = 1'b0;
    tx_data  = 8'd0;
    case (state_q)
      IDLE: begin
        if (start) state_d = rs_skip ? DATA : STATUS;
      end
      STATUS: begin
        tx_valid = 1'b1;
        tx_data  = {4'hC, MIDI_CHANNEL};
        if (tx_ready) state_d = DATA;
      end
      DATA: begin
        tx_valid = 1'b1;
        tx_data  = {1'b0, msg_q};
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_preset_sequencer.sv
// Directed self-checking bench for preset_sequencer (default parameters).
module tb_preset_sequencer;

  logic       clk;
  logic       rst;
  logic [1:0] btn_index;
  logic       save_mode;
  logic       rx_prog_valid;
  logic [6:0] rx_prog;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       saved;
  logic [1:0] active_slot;
  logic [1:0] state_dbg;

  int checks = 0;
  int fails  = 0;

  preset_sequencer dut (
    .clk(clk), .rst(rst), .btn_index(btn_index), .save_mode(save_mode),
    .rx_prog_valid(rx_prog_valid), .rx_prog(rx_prog), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .saved(saved),
    .active_slot(active_slot), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change and outputs are sampled 1 time unit after posedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] idx, input logic sv);
    btn_index = idx;
    save_mode = sv;
    tick();
    btn_index = 2'd0;
    save_mode = 1'b0;
  endtask

  task automatic capture(input logic [6:0] prog);
    rx_prog_valid = 1'b1;
    rx_prog       = prog;
    tick();
    rx_prog_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; btn_index = 2'd0; save_mode = 1'b0;
    rx_prog_valid = 1'b0; rx_prog = 7'd0; tx_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({tx_data, tx_valid, busy, saved, active_slot} !== 13'd0) begin
      fails++;
      $display("FAIL reset_outputs: got data=%h valid=%b busy=%b saved=%b slot=%0d, expected all zero",
               tx_data, tx_valid, busy, saved, active_slot);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_recall();
    press(2'd2, 1'b0);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hC0 || busy !== 1'b1) begin
      fails++; $display("FAIL recall_status: got valid=%b data=%h busy=%b, expected 1 c0 1", tx_valid, tx_data, busy);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h01 || busy !== 1'b1) begin
      fails++; $display("FAIL recall_data: got valid=%b data=%h busy=%b, expected 1 01 1", tx_valid, tx_data, busy);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || active_slot !== 2'd2) begin
      fails++; $display("FAIL recall_end: got valid=%b busy=%b slot=%0d, expected 0 0 2", tx_valid, busy, active_slot);
    end
  endtask

  task automatic test_save_recall();
    capture(7'h2A);
    checks++;
    if (saved !== 1'b0) begin
      fails++; $display("FAIL capture_no_pulse: got saved=%b, expected 0", saved);
    end
    press(2'd1, 1'b1);
    checks++;
    if (saved !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL save_pulse: got saved=%b busy=%b, expected 1 0", saved, busy);
    end
    tick();
    checks++;
    if (saved !== 1'b0) begin
      fails++; $display("FAIL save_pulse_width: got saved=%b, expected 0", saved);
    end
    press(2'd1, 1'b0);
    checks++;
    if (tx_data !== 8'hC0) begin
      fails++; $display("FAIL saved_status: got %h, expected c0", tx_data);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h2A) begin
      fails++; $display("FAIL saved_data: got valid=%b data=%h, expected 1 2a", tx_valid, tx_data);
    end
    tick();
  endtask

  task automatic test_save_no_capture();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    press(2'd3, 1'b1);
    checks++;
    if (saved !== 1'b0) begin
      fails++; $display("FAIL save_ignored: got saved=%b, expected 0", saved);
    end
    tick();
    checks++;
    if (saved !== 1'b0) begin
      fails++; $display("FAIL save_ignored_late: got saved=%b, expected 0", saved);
    end
    press(2'd3, 1'b0);
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h02) begin
      fails++; $display("FAIL slot3_init: got valid=%b data=%h, expected 1 02", tx_valid, tx_data);
    end
    tick();
  endtask

  task automatic test_stall_pending();
    tx_ready = 1'b0;
    press(2'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      btn_index = (i == 0) ? 2'd1 : ((i == 2) ? 2'd3 : 2'd0);
      tick();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'hC0 || state_dbg !== 2'd1) begin
        fails++; $display("FAIL stall_hold[%0d]: got valid=%b data=%h state=%0d, expected 1 c0 1",
                          i, tx_valid, tx_data, state_dbg);
      end
    end
    btn_index = 2'd0;
    tx_ready  = 1'b1;
    tick();
    checks++;
    if (tx_data !== 8'h01) begin
      fails++; $display("FAIL stall_first_data: got %h, expected 01", tx_data);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b0) begin
      fails++; $display("FAIL idle_gap: got valid=%b, expected 0", tx_valid);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hC0) begin
      fails++; $display("FAIL pending_status: got valid=%b data=%h, expected 1 c0", tx_valid, tx_data);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h02) begin
      fails++; $display("FAIL pending_latest: got valid=%b data=%h, expected 1 02", tx_valid, tx_data);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (tx_valid !== 1'b0 || active_slot !== 2'd3) begin
        fails++; $display("FAIL single_pending[%0d]: got valid=%b slot=%0d, expected 0 3", i, tx_valid, active_slot);
      end
    end
  endtask

  task automatic test_inflight_save();
    press(2'd2, 1'b0);
    btn_index = 2'd2; save_mode = 1'b1;
    rx_prog_valid = 1'b1; rx_prog = 7'h33;
    tick();
    btn_index = 2'd0; save_mode = 1'b0; rx_prog_valid = 1'b0;
    checks++;
    if (tx_data !== 8'h01 || saved !== 1'b1) begin
      fails++; $display("FAIL inflight_latched: got data=%h saved=%b, expected 01 1", tx_data, saved);
    end
    tick();
    press(2'd2, 1'b0);
    tick();
    checks++;
    if (tx_data !== 8'h33) begin
      fails++; $display("FAIL bypass_save: got %h, expected 33", tx_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    capture(7'h55);
    press(2'd1, 1'b1);
    press(2'd1, 1'b0);
    tick();
    checks++;
    if (tx_data !== 8'h55 || state_dbg !== 2'd2) begin
      fails++; $display("FAIL pre_abort_data: got data=%h state=%0d, expected 55 2", tx_data, state_dbg);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({tx_data, tx_valid, busy, saved, active_slot} !== 13'd0) begin
      fails++; $display("FAIL abort_reset: got data=%h valid=%b busy=%b saved=%b slot=%0d, expected all zero",
                        tx_data, tx_valid, busy, saved, active_slot);
    end
    #3;
    rst = 1'b1;
    tick();
    checks++;
    if (tx_valid !== 1'b0) begin
      fails++; $display("FAIL no_resume: got valid=%b, expected 0", tx_valid);
    end
    press(2'd1, 1'b1);
    checks++;
    if (saved !== 1'b0) begin
      fails++; $display("FAIL capture_cleared: got saved=%b, expected 0", saved);
    end
    press(2'd1, 1'b0);
    tick();
    checks++;
    if (tx_data !== 8'h00) begin
      fails++; $display("FAIL slot1_restored: got %h, expected 00", tx_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    press(2'd1, 1'b0);
    btn_index = 2'd2;
    tick();
    btn_index = 2'd0;
    checks++;
    if (tx_data !== 8'h00) begin
      fails++; $display("FAIL b2b_first_data: got %h, expected 00", tx_data);
    end
    tick();
    tick();
`ifdef PRESET_RUNNING_STATUS_EN
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
      fails++; $display("FAIL running_status: got valid=%b data=%h, expected 1 01", tx_valid, tx_data);
    end
`else
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hC0) begin
      fails++; $display("FAIL b2b_status: got valid=%b data=%h, expected 1 c0", tx_valid, tx_data);
    end
    tick();
    checks++;
    if (tx_data !== 8'h01) begin
      fails++; $display("FAIL b2b_second_data: got %h, expected 01", tx_data);
    end
`endif
    tick();
    checks++;
    if (busy !== 1'b0 || active_slot !== 2'd2) begin
      fails++; $display("FAIL b2b_end: got busy=%b slot=%0d, expected 0 2", busy, active_slot);
    end
  endtask

  initial begin
    test_reset();
    test_recall();
    test_save_recall();
    test_save_no_capture();
    test_stall_pending();
    test_inflight_save();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
